// File: rtl/oled_rx_pkg.sv
// rtl/oled_rx_pkg.sv - opcode constants, argument-count lookup and decoder state type for oled_spi_rx
package oled_rx_pkg;

  localparam logic [7:0] OP_SET_COL_LO = 8'h00;
  localparam logic [7:0] OP_SET_COL_HI = 8'h10;
  localparam logic [7:0] OP_SET_PAGE   = 8'hB0;
  localparam logic [7:0] OP_DISP_OFF   = 8'hAE;
  localparam logic [7:0] OP_DISP_ON    = 8'hAF;

  typedef enum logic [1:0] {
    ST_CMD  = 2'd0,
    ST_ARG2 = 2'd1,
    ST_ARG1 = 2'd2
  } dec_state_t;

  // Number of argument bytes that follow an opcode in the supported subset.
  function automatic logic [1:0] arg_count(input logic [7:0] op);
    case (op)
      8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
      8'hD5, 8'hD9, 8'hDA, 8'hDB: arg_count = 2'd1;
      8'h21, 8'h22:               arg_count = 2'd2;
      default:                    arg_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// rtl/spi_byte_rx.sv - pin synchronizers, sck edge detect and MSB-first byte assembly
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clkin_50m,
  input  logic       reset_n,
  input  logic       sck,
  input  logic       sdin,
  input  logic       cs,
  input  logic       dc,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic       frame_err
);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] sdin_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] dc_sync;
  logic                   sck_q;
  logic                   cs_q;
  logic [6:0]             shreg;
  logic [2:0]             bit_cnt;
  logic                   sck_s;
  logic                   sdin_s;
  logic                   cs_s;
  logic                   dc_s;
  logic                   sck_rise;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign sdin_s   = sdin_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign dc_s     = dc_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_q;

  // cs synchronizer resets to deselected so reset never fabricates a cs edge
  always_ff @(posedge clkin_50m or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync  <= '0;
      sdin_sync <= '0;
      cs_sync   <= '1;
      dc_sync   <= '0;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], sdin};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], dc};
      sck_q     <= sck_s;
      cs_q      <= cs_s;
    end
  end

  always_ff @(posedge clkin_50m or negedge reset_n) begin
    if (!reset_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      // Deselect wins over a coincident sck rise; the error uses the pre-edge count.
      if (cs_s) begin
        bit_cnt <= '0;
        if (!cs_q && bit_cnt != 3'd0)
          frame_err <= 1'b1;
      end else if (sck_rise) begin
        shreg <= {shreg[5:0], sdin_s};
        if (bit_cnt == 3'd7) begin
          byte_data  <= {shreg, sdin_s};
          byte_dc    <= dc_s;
          byte_valid <= 1'b1;
          bit_cnt    <= '0;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/oled_spi_rx.sv
// rtl/oled_spi_rx.sv - OLED SPI receive model: command decode and frame-buffer write generation
module oled_spi_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int COLS        = 128,
  parameter int PAGES       = 8
) (
  input  logic       clkin_50m,
  input  logic       reset_n,
  input  logic       sck,
  input  logic       sdin,
  input  logic       cs,
  input  logic       dc,
  output logic       fb_we,
  output logic [9:0] fb_addr,
  output logic [7:0] fb_wdata,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       cmd_is_arg,
  output logic       disp_on,
  output logic       frame_err
);
  import oled_rx_pkg::*;

  localparam int COL_W  = $clog2(COLS);
  localparam int PAGE_W = $clog2(PAGES);

  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              rx_dc;

  dec_state_t        state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [PAGE_W-1:0] page_q, page_d;
  logic              disp_q, disp_d;
  logic              we_q, we_d;
  logic [9:0]        addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              cv_q, cv_d;
  logic [7:0]        cbyte_q, cbyte_d;
  logic              carg_q, carg_d;
  logic [7:0]        col_wide;

  spi_byte_rx #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_byte_rx (
    .clkin_50m (clkin_50m),
    .reset_n   (reset_n),
    .sck       (sck),
    .sdin      (sdin),
    .cs        (cs),
    .dc        (dc),
    .byte_valid(rx_valid),
    .byte_data (rx_byte),
    .byte_dc   (rx_dc),
    .frame_err (frame_err)
  );

  assign col_wide = 8'(col_q);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    page_d  = page_q;
    disp_d  = disp_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cv_d    = 1'b0;
    cbyte_d = cbyte_q;
    carg_d  = carg_q;
    if (rx_valid) begin
      if (rx_dc) begin
        // Data always writes at the pre-increment address and cancels pending arguments.
        we_d    = 1'b1;
        addr_d  = 10'({page_q, col_q});
        wdata_d = rx_byte;
        col_d   = col_q + 1'b1;
        state_d = ST_CMD;
      end else begin
        cv_d    = 1'b1;
        cbyte_d = rx_byte;
        case (state_q)
          ST_CMD: begin
            carg_d = 1'b0;
            if ((rx_byte & 8'hF0) == OP_SET_COL_LO)
              col_d = COL_W'({col_wide[7:4], rx_byte[3:0]});
            else if ((rx_byte & 8'hF0) == OP_SET_COL_HI)
              col_d = COL_W'({col_wide[7], rx_byte[2:0], col_wide[3:0]});
            else if ((rx_byte & 8'hF8) == OP_SET_PAGE)
              page_d = PAGE_W'(rx_byte[2:0]);
            else if (rx_byte == OP_DISP_OFF || rx_byte == OP_DISP_ON)
              disp_d = rx_byte[0];
            case (arg_count(rx_byte))
              2'd1:    state_d = ST_ARG1;
              2'd2:    state_d = ST_ARG2;
              default: state_d = ST_CMD;
            endcase
          end
          ST_ARG2: begin
            carg_d  = 1'b1;
            state_d = ST_ARG1;
          end
          ST_ARG1: begin
            carg_d  = 1'b1;
            state_d = ST_CMD;
          end
          default: begin
            carg_d  = 1'b0;
            state_d = ST_CMD;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clkin_50m or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_CMD;
      col_q   <= '0;
      page_q  <= '0;
      disp_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cv_q    <= 1'b0;
      cbyte_q <= '0;
      carg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      page_q  <= page_d;
      disp_q  <= disp_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cv_q    <= cv_d;
      cbyte_q <= cbyte_d;
      carg_q  <= carg_d;
    end
  end

  assign fb_we      = we_q;
  assign fb_addr    = addr_q;
  assign fb_wdata   = wdata_q;
  assign cmd_valid  = cv_q;
  assign cmd_byte   = cbyte_q;
  assign cmd_is_arg = carg_q;
  assign disp_on    = disp_q;

endmodule

// File: tb/tb_oled_spi_rx.sv
// tb/tb_oled_spi_rx.sv - directed self-checking bench for oled_spi_rx
module tb_oled_spi_rx;

  logic       clkin_50m;
  logic       reset_n;
  logic       sck;
  logic       sdin;
  logic       cs;
  logic       dc;
  logic       fb_we;
  logic [9:0] fb_addr;
  logic [7:0] fb_wdata;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       cmd_is_arg;
  logic       disp_on;
  logic       frame_err;

  int tests_run    = 0;
  int tests_failed = 0;

  int         we_cnt = 0;
  int         cv_cnt = 0;
  int         fe_cnt = 0;
  logic [9:0] addr_log[$];
  logic [7:0] data_log[$];

  int we0, cv0, fe0, n0;

  oled_spi_rx #(
    .SYNC_STAGES(2),
    .COLS       (128),
    .PAGES      (8)
  ) dut (
    .clkin_50m (clkin_50m),
    .reset_n   (reset_n),
    .sck       (sck),
    .sdin      (sdin),
    .cs        (cs),
    .dc        (dc),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_wdata  (fb_wdata),
    .cmd_valid (cmd_valid),
    .cmd_byte  (cmd_byte),
    .cmd_is_arg(cmd_is_arg),
    .disp_on   (disp_on),
    .frame_err (frame_err)
  );

  initial clkin_50m = 1'b0;
  always #10 clkin_50m = ~clkin_50m;

  always @(negedge clkin_50m) begin
    if (fb_we) begin
      we_cnt++;
      addr_log.push_back(fb_addr);
      data_log.push_back(fb_wdata);
    end
    if (cmd_valid) cv_cnt++;
    if (frame_err) fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input logic d, input int n);
    for (int i = 0; i < n; i++) begin
      sdin = b[7-i];
      dc   = d;
      #100 sck = 1'b1;
      #100 sck = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d);
    send_bits(b, d, 8);
    #40;
  endtask

  task automatic snap;
    we0 = we_cnt;
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    n0  = addr_log.size();
  endtask

  initial begin
    reset_n = 1'b0;
    sck = 1'b0; sdin = 1'b0; cs = 1'b1; dc = 1'b0;
    #100 reset_n = 1'b1;
    #100;
    check("rst_fb_we", fb_we, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_wdata", fb_wdata, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_byte", cmd_byte, 0);
    check("rst_cmd_is_arg", cmd_is_arg, 0);
    check("rst_disp_on", disp_on, 0);
    check("rst_frame_err", frame_err, 0);

    // 0xAF with an exact latency probe on the last bit
    cs = 1'b0;
    #100;
    snap();
    send_bits(8'hAF, 1'b0, 7);
    sdin = 1'b1;
    #100 sck = 1'b1;
    repeat (3) @(posedge clkin_50m);
    #1 check("lat_early", cmd_valid, 0);
    @(posedge clkin_50m);
    #1 check("lat_hit", cmd_valid, 1);
    @(posedge clkin_50m);
    #1 check("lat_width", cmd_valid, 0);
    @(negedge clkin_50m);
    sck = 1'b0;
    #100;
    check("af_count", cv_cnt - cv0, 1);
    check("af_byte", cmd_byte, 8'hAF);
    check("af_is_arg", cmd_is_arg, 0);
    check("af_disp_on", disp_on, 1);

    // page 3, col 0x32 -> 3*128+50 = 434
    snap();
    send_byte(8'hB3, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h55, 1'b1);
    check("p3_cmd_count", cv_cnt - cv0, 3);
    check("p3_we_count", we_cnt - we0, 1);
    check("p3_addr", addr_log[n0], 434);
    check("p3_wdata", data_log[n0], 8'h55);
    check("p3_hold_addr", fb_addr, 434);

    // page 7, col 126: three writes wrap to col 0 within page 7
    snap();
    send_byte(8'hB7, 1'b0);
    send_byte(8'h0E, 1'b0);
    send_byte(8'h17, 1'b0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    check("wrap_we_count", we_cnt - we0, 3);
    check("wrap_addr0", addr_log[n0], 1022);
    check("wrap_addr1", addr_log[n0+1], 1023);
    check("wrap_addr2", addr_log[n0+2], 896);
    check("wrap_data2", data_log[n0+2], 8'h33);

    // 0xB5 as an argument of 0x81 must not change page
    snap();
    send_byte(8'h81, 1'b0);
    check("c81_is_arg", cmd_is_arg, 0);
    send_byte(8'hB5, 1'b0);
    check("arg_byte", cmd_byte, 8'hB5);
    check("arg_is_arg", cmd_is_arg, 1);
    send_byte(8'h44, 1'b1);
    check("arg_page_kept", addr_log[n0], 897);

    // two-argument opcode, then FSM must be back in CMD
    snap();
    send_byte(8'h21, 1'b0);
    send_byte(8'h00, 1'b0);
    check("a2_first_is_arg", cmd_is_arg, 1);
    send_byte(8'h7F, 1'b0);
    check("a2_second_is_arg", cmd_is_arg, 1);
    check("a2_cmd_count", cv_cnt - cv0, 3);
    send_byte(8'hB1, 1'b0);
    check("a2_back_cmd", cmd_is_arg, 0);
    send_byte(8'h99, 1'b1);
    check("a2_page1_addr", addr_log[n0], 130);

    // data aborts an argument sequence
    send_byte(8'h22, 1'b0);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hAE, 1'b0);
    check("abort_is_arg", cmd_is_arg, 0);
    check("abort_disp_off", disp_on, 0);

    // cs raised with zero bits pending: no error
    snap();
    cs = 1'b1;
    #200;
    check("cs_clean_ferr", fe_cnt - fe0, 0);

    // cs raised after 5 bits
    cs = 1'b0;
    #100;
    snap();
    send_bits(8'hFF, 1'b1, 5);
    cs = 1'b1;
    #200;
    check("ferr_count", fe_cnt - fe0, 1);
    check("ferr_no_we", we_cnt - we0, 0);
    check("ferr_no_cv", cv_cnt - cv0, 0);
    cs = 1'b0;
    #100;
    send_byte(8'h66, 1'b1);
    check("ferr_next_addr", addr_log[n0], 132);
    check("ferr_next_data", data_log[n0], 8'h66);

    // reset_n pulsed after 3 bits of a data byte
    snap();
    send_bits(8'hA5, 1'b1, 3);
    reset_n = 1'b0;
    #40;
    check("mid_rst_addr", fb_addr, 0);
    check("mid_rst_wdata", fb_wdata, 0);
    check("mid_rst_cmd_byte", cmd_byte, 0);
    reset_n = 1'b1;
    cs = 1'b1;
    #200;
    check("mid_rst_no_ferr", fe_cnt - fe0, 0);
    check("mid_rst_no_we", we_cnt - we0, 0);
    check("mid_rst_no_cv", cv_cnt - cv0, 0);
    cs = 1'b0;
    #100;
    send_byte(8'hB2, 1'b0);
    send_byte(8'h5A, 1'b1);
    check("post_rst_cmd", cmd_byte, 8'hB2);
    check("post_rst_addr", fb_addr, 256);
    check("post_rst_data", fb_wdata, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
